// File: rtl/dense_pkg.sv
// Shared constants, memory map and sequencer state encoding for the
// 784->10 dense layer engine.
package dense_pkg;

    localparam int ADDR_W    = 14;
    localparam int DATA_W    = 24;
    localparam int N_IN      = 784;
    localparam int N_OUT     = 10;
    localparam int ACC_WIDTH = 48;
    localparam int X_W       = 8;    // pixel width carried in rdata[7:0]
    localparam int I_W       = 10;   // input-element counter width
    localparam int J_W       = 4;    // neuron counter width

    localparam logic [ADDR_W-1:0] X_BASE = 14'h0000;
    localparam logic [ADDR_W-1:0] W_BASE = 14'h1000;
    localparam logic [ADDR_W-1:0] B_BASE = 14'h2EA0;
    localparam logic [ADDR_W-1:0] Y_BASE = 14'h3000;

    localparam logic [I_W-1:0] I_LAST = I_W'(N_IN - 1);
    localparam logic [J_W-1:0] J_LAST = J_W'(N_OUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        BIAS_RD,
        X_RD,
        W_RD,
        DRAIN,
        Y_WR,
        DONE
    } state_t;

endpackage

// File: rtl/dense_mac_sat.sv
// Accumulator for one neuron: bias load, unsigned-pixel x signed-weight
// accumulate, and a combinational clamp of the sum to the 24-bit range.
module dense_mac_sat
    import dense_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load_bias,
    input  logic              i_accumulate,
    input  logic              i_load_x,
    input  logic [DATA_W-1:0] i_rdata,
    output logic [DATA_W-1:0] o_sat
);

    logic [X_W-1:0]              r_x;
    logic [ACC_WIDTH-1:0]        r_acc;
    logic signed [X_W:0]         w_x_s;
    logic signed [X_W+DATA_W:0]  w_prod_raw;
    logic [ACC_WIDTH-1:0]        w_prod;
    logic [ACC_WIDTH-1:0]        w_bias;
    logic [ACC_WIDTH-DATA_W:0]   w_hi;

    // Pixel is unsigned: a zero top bit makes the signed multiply exact.
    assign w_x_s      = $signed({1'b0, r_x});
    assign w_prod_raw = w_x_s * $signed(i_rdata);
    assign w_prod     = {{(ACC_WIDTH-X_W-DATA_W-1){w_prod_raw[X_W+DATA_W]}}, w_prod_raw};
    assign w_bias     = {{(ACC_WIDTH-DATA_W){i_rdata[DATA_W-1]}}, i_rdata};

    // Bits above the 24-bit sign position must all agree for the sum to fit.
    assign w_hi = r_acc[ACC_WIDTH-1:DATA_W-1];

    // Clamp the accumulator to [-2^23, 2^23-1].
    // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        o_sat = r_acc[DATA_W-1:0];
        if (!(&w_hi) && (|w_hi)) begin
            o_sat = r_acc[ACC_WIDTH-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                       : {1'b0, {(DATA_W-1){1'b1}}};
        end
    end

    // Accumulator and latched pixel.
    // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_x   <= '0;
        end else begin
            if (i_load_bias) begin
                r_acc <= w_bias;
            end else if (i_accumulate) begin
                r_acc <= r_acc + w_prod;
            end
            if (i_load_x) begin
                r_x <= i_rdata[X_W-1:0];
            end
        end
    end

endmodule

// File: rtl/dense_layer_engine.sv
// Sequencer for the dense layer: walks bias, pixel and weight reads through
// the single-port RAM, writes saturated neuron outputs and tracks argmax.
module dense_layer_engine
    import dense_pkg::*;
#(
    parameter int ADDRESS_WIDTH = ADDR_W,
    parameter int DATA_WIDTH    = DATA_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [3:0]               class_idx,
    output logic                     ram_en,
    output logic [3:0]               ram_we,
    output logic [ADDRESS_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0]    ram_wdata,
    input  logic [DATA_WIDTH-1:0]    ram_rdata
);

    state_t                   r_state;
    state_t                   w_next;
    logic [I_W-1:0]           r_i;
    logic [J_W-1:0]           r_j;
    logic [ADDRESS_WIDTH-1:0] r_w_ptr;
    logic [DATA_WIDTH-1:0]    r_best_val;
    logic [J_W-1:0]           r_best_idx;
    logic [3:0]               r_class_idx;
    logic                     w_load_bias;
    logic                     w_accumulate;
    logic                     w_load_x;
    logic [DATA_WIDTH-1:0]    w_sat;
    logic                     w_take;

    dense_mac_sat u_mac (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_load_bias  (w_load_bias),
        .i_accumulate (w_accumulate),
        .i_load_x     (w_load_x),
        .i_rdata      (ram_rdata),
        .o_sat        (w_sat)
    );

    // First neuron always seeds the argmax; later ones must be strictly larger.
    assign w_take    = (r_j == '0) || ($signed(w_sat) > $signed(r_best_val));
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);
    assign class_idx = r_class_idx;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state, RAM port and MAC controls decoded from the current state.
    always_comb begin
        w_next       = r_state;
        ram_en       = 1'b0;
        ram_we       = 4'h0;
        ram_addr     = '0;
        ram_wdata    = '0;
        w_load_bias  = 1'b0;
        w_accumulate = 1'b0;
        w_load_x     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_next = BIAS_RD;
            end
            BIAS_RD: begin
                ram_en   = 1'b1;
                ram_addr = B_BASE + ADDRESS_WIDTH'(r_j);
                w_next   = X_RD;
            end
            X_RD: begin
                // rdata holds the bias on the first pass, else W of element i-1.
                ram_en       = 1'b1;
                ram_addr     = X_BASE + ADDRESS_WIDTH'(r_i);
                w_load_bias  = (r_i == '0);
                w_accumulate = (r_i != '0);
                w_next       = W_RD;
            end
            W_RD: begin
                ram_en   = 1'b1;
                ram_addr = r_w_ptr;
                w_load_x = 1'b1;
                w_next   = (r_i == I_LAST) ? DRAIN : X_RD;
            end
            DRAIN: begin
                w_accumulate = 1'b1;
                w_next       = Y_WR;
            end
            Y_WR: begin
                ram_en    = 1'b1;
                ram_we    = 4'hF;
                ram_addr  = Y_BASE + ADDRESS_WIDTH'(r_j);
                ram_wdata = w_sat;
                w_next    = (r_j == J_LAST) ? DONE : BIAS_RD;
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Counters, weight pointer and running argmax.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_i         <= '0;
            r_j         <= '0;
            r_w_ptr     <= '0;
            r_best_val  <= '0;
            r_best_idx  <= '0;
            r_class_idx <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_j     <= '0;
                        r_w_ptr <= W_BASE;
                    end
                end
                BIAS_RD: begin
                    r_i <= '0;
                end
                W_RD: begin
                    r_w_ptr <= r_w_ptr + 1'b1;
                    if (r_i != I_LAST) r_i <= r_i + 1'b1;
                end
                Y_WR: begin
                    if (w_take) begin
                        r_best_val <= w_sat;
                        r_best_idx <= r_j;
                    end
                    // Publish the winner on entry to DONE so it is valid with the done pulse.
                    if (r_j == J_LAST) begin
                        r_class_idx <= w_take ? r_j : r_best_idx;
                    end else begin
                        r_j <= r_j + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
